// File: rtl/scan_cfg_ctrl_if.sv
// Host-side configuration bus for scan_cfg_ctrl.
//   cfg_data/cfg_valid/cfg_ready : configuration words, valid/ready handshake
//   rb_data/rb_valid             : readback words, one-cycle pulse, no backpressure
// master = host/programming interface, slave = controller.
interface scan_cfg_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (
    output cfg_data, cfg_valid,
    input  cfg_ready, rb_data, rb_valid
  );

  modport slave (
    input  cfg_data, cfg_valid,
    output cfg_ready, rb_data, rb_valid
  );
endinterface

// File: rtl/scan_cfg_ctrl.sv
// Scan configuration chain loader.
// Accepts host words over cfg (valid/ready), shifts them MSB-first onto the
// chain's scan input with scan enable asserted for exactly CHAIN_LEN cycles,
// and packs the bits displaced from the chain's scan output into readback words.
// Ports:
//   clk, rst_n   : chain clock, async active-low reset
//   start, abort : begin a load (IDLE only) / synchronous cancel
//   cfg          : host bus (cfg_data/valid/ready, rb_data/valid)
//   chain_si/en  : scan_in of first cell / scan_en of all cells
//   chain_so     : scan_out of last cell
//   busy, done   : LOAD/SHIFT indicator, one-cycle completion pulse
module scan_cfg_ctrl #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  scan_cfg_if.slave   cfg,
  output logic        chain_si,
  output logic        chain_en,
  input  logic        chain_so,
  output logic        busy,
  output logic        done
);

  localparam int unsigned RW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [RW-1:0]     rem;
  logic [BW-1:0]     bitcnt;
  logic [BW-1:0]     wlen;
  logic [WORD_W-1:0] sbuf;
  logic [WORD_W-2:0] rb_acc;
  logic [WORD_W-1:0] rb_next;
  logic [WORD_W-1:0] rb_data_q;
  logic              rb_valid_q;
  logic              ready;
  logic              take;
  logic              last_bit;
  logic              more;
  logic [BW-1:0]     load_bits;

  function automatic logic [BW-1:0] word_bits(input logic [RW-1:0] r);
    if (32'(r) >= WORD_W) return BW'(WORD_W);
    else                  return BW'(r);
  endfunction

  assign last_bit  = (bitcnt == BW'(1));
  assign more      = (rem > RW'(1));
  assign take      = ready && cfg.cfg_valid;
  // A reload on the last SHIFT cycle sees rem before this cycle's decrement.
  assign load_bits = word_bits((state == S_SHIFT) ? rem - RW'(1) : rem);
  assign rb_next   = {rb_acc, chain_so};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    chain_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ready = 1'b1;
        if (cfg.cfg_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        chain_en = 1'b1;
        if (last_bit) begin
          if (more) begin
            ready = 1'b1;
            if (!cfg.cfg_valid) state_nxt = S_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem        <= '0;
      bitcnt     <= '0;
      wlen       <= '0;
      sbuf       <= '0;
      rb_acc     <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy       <= (state_nxt == S_LOAD) || (state_nxt == S_SHIFT);
      done       <= (state_nxt == S_DONE);
      rb_valid_q <= 1'b0;
      if (abort) begin
        rem    <= '0;
        bitcnt <= '0;
        sbuf   <= '0;
      end else begin
        if (state == S_IDLE && start) rem <= RW'(CHAIN_LEN);
        if (chain_en) begin
          sbuf   <= sbuf << 1;
          rem    <= rem - RW'(1);
          bitcnt <= bitcnt - BW'(1);
          rb_acc <= rb_next[WORD_W-2:0];
          if (last_bit) begin
            // Left-align a partial word so its sampled bits sit at the top.
            rb_data_q  <= rb_next << (BW'(WORD_W) - wlen);
            rb_valid_q <= 1'b1;
          end
        end
        if (take) begin
          sbuf   <= cfg.cfg_data;
          bitcnt <= load_bits;
          wlen   <= load_bits;
        end
      end
    end
  end

  assign chain_si     = sbuf[WORD_W-1];
  assign cfg.cfg_ready = ready;
  assign cfg.rb_data  = rb_data_q;
  assign cfg.rb_valid = rb_valid_q;

endmodule

// File: tb/tb_scan_cfg_ctrl.sv
// Directed bench for scan_cfg_ctrl: a 64x8 instance and a 10x4 instance,
// each driving a behavioural scan chain model.
module tb_scan_cfg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, abort_a, si_a, en_a, so_a, busy_a, done_a;
  logic start_b, abort_b, si_b, en_b, so_b, busy_b, done_b;

  scan_cfg_if #(.WORD_W(8)) if_a ();
  scan_cfg_if #(.WORD_W(4)) if_b ();

  scan_cfg_ctrl #(.CHAIN_LEN(64), .WORD_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .cfg(if_a),
    .chain_si(si_a), .chain_en(en_a), .chain_so(so_a), .busy(busy_a), .done(done_a)
  );

  scan_cfg_ctrl #(.CHAIN_LEN(10), .WORD_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .cfg(if_b),
    .chain_si(si_b), .chain_en(en_b), .chain_so(so_b), .busy(busy_b), .done(done_b)
  );

  // Chain models: bit 0 is the head cell, the top bit drives scan_out.
  logic [63:0] chain_a = 64'hDEAD_BEEF_0123_4567;
  logic [9:0]  chain_b = 10'b1011001110;
  always @(posedge clk) if (en_a) chain_a <= {chain_a[62:0], si_a};
  always @(posedge clk) if (en_b) chain_b <= {chain_b[8:0], si_b};
  assign so_a = chain_a[63];
  assign so_b = chain_b[9];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          r_en, r_maxrun, r_done, r_stall, r_rb;
  logic [63:0] r_rbw;
  logic        r_busy1, r_rb_at_done, r_busy_at_done, r_post_busy, r_post_en;

  localparam logic [63:0] P = 64'hA53C_5AC3_0FF0_9669;
  localparam logic [63:0] Q = 64'h1122_4488_77EE_DDBB;
  localparam logic [63:0] R = 64'hC001_D00D_FACE_0B1E;

  task automatic run_a(input logic [63:0] pat, input bit gaps, input int abort_at);
    int idx, run, abort_cyc;
    bit aborted;
    idx = 0; run = 0; abort_cyc = 0; aborted = 0;
    r_en = 0; r_maxrun = 0; r_done = -1; r_stall = 0; r_rb = 0; r_rbw = '0;
    r_busy1 = 0; r_rb_at_done = 0; r_busy_at_done = 1; r_post_busy = 1; r_post_en = 1;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int c = 1; c < 400; c++) begin
      if (aborted && c == abort_cyc + 1) begin
        r_post_busy = busy_a;
        r_post_en   = en_a;
        abort_a     = 1'b0;
      end
      if_a.cfg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if_a.cfg_data  = (idx < 8) ? pat[63-8*idx -: 8] : 8'h00;
      if (c == 1) r_busy1 = busy_a;
      if (en_a) begin
        r_en++; run++;
        if (run > r_maxrun) r_maxrun = run;
      end else run = 0;
      if (if_a.cfg_ready && !if_a.cfg_valid) r_stall++;
      if (if_a.rb_valid) begin
        if (r_rb < 8) r_rbw[63-8*r_rb -: 8] = if_a.rb_data;
        r_rb++;
      end
      if (done_a && r_done < 0) begin
        r_done = c;
        r_rb_at_done = if_a.rb_valid;
        r_busy_at_done = busy_a;
      end
      if (abort_at >= 0 && !aborted && r_en == abort_at) begin
        abort_a = 1'b1; aborted = 1; abort_cyc = c;
      end
      if (if_a.cfg_valid && if_a.cfg_ready) idx++;
      @(posedge clk); #1;
      if (r_done >= 0) break;
      if (aborted && c >= abort_cyc + 10) break;
    end
    if_a.cfg_valid = 1'b0;
    abort_a = 1'b0;
  endtask

  logic [63:0] snap;
  logic [9:0]  snap_b;
  logic [11:0] rbb;
  int          b_en, b_done, b_rb, b_idx;
  localparam logic [11:0] WB = 12'hF0B;

  initial begin
    rst_n = 1'b0;
    start_a = 0; abort_a = 0; if_a.cfg_valid = 0; if_a.cfg_data = '0;
    start_b = 0; abort_b = 0; if_b.cfg_valid = 0; if_b.cfg_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl_a", {busy_a, done_a, en_a, if_a.cfg_ready, if_a.rb_valid, si_a}, 0);
    check("reset_rb_a", if_a.rb_data, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Gapless load of P; readback is the initial chain contents.
    snap = chain_a;
    run_a(P, 0, -1);
    check("t1_en_cnt", r_en, 64);
    check("t1_en_run", r_maxrun, 64);
    check("t1_done_cyc", r_done, 66);
    check("t1_busy_c1", r_busy1, 1);
    check("t1_busy_done", r_busy_at_done, 0);
    check("t1_rbv_done", r_rb_at_done, 1);
    check("t1_rb_cnt", r_rb, 8);
    check("t1_rb_words", r_rbw, snap);
    check("t1_chain", chain_a, P);

    // Q after P: readback returns P in order.
    run_a(Q, 0, -1);
    check("t2_done_cyc", r_done, 66);
    check("t2_rb_words", r_rbw, P);
    check("t2_chain", chain_a, Q);

    // Random valid gaps: each stall adds exactly one held cycle.
    run_a(P, 1, -1);
    check("t3_en_cnt", r_en, 64);
    check("t3_done_cyc", r_done, 66 + r_stall);
    check("t3_rb_words", r_rbw, Q);
    check("t3_chain", chain_a, P);

    // Abort after 20 shifts, then a full load of R.
    run_a(Q, 0, 20);
    check("t4_en_cnt", r_en, 20);
    check("t4_post_busy", r_post_busy, 0);
    check("t4_post_en", r_post_en, 0);
    check("t4_no_done", (r_done >= 0), 0);
    check("t4_rb_cnt", r_rb, 2);
    check("t4_rb_words", r_rbw[63:48], P[63:48]);
    check("t4_chain", chain_a, {P[43:0], Q[63:44]});
    run_a(R, 0, -1);
    check("t4r_done_cyc", r_done, 66);
    check("t4r_rb_words", r_rbw, {P[43:0], Q[63:44]});
    check("t4r_chain", chain_a, R);

    // Reset pulsed mid-shift with start held high.
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    if_a.cfg_valid = 1'b1; if_a.cfg_data = 8'h81;
    repeat (12) @(posedge clk);
    #2; rst_n = 1'b0; start_a = 1'b1;
    #1;
    check("t5_rst_ctl", {busy_a, done_a, en_a, if_a.cfg_ready, if_a.rb_valid, si_a}, 0);
    check("t5_rst_rb", if_a.rb_data, 0);
    @(posedge clk); #1;
    check("t5_start_in_rst", busy_a, 0);
    @(negedge clk); rst_n = 1'b1; start_a = 1'b0; if_a.cfg_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t5_idle", {busy_a, en_a, if_a.cfg_ready}, 0);
    snap = chain_a;
    run_a(P, 0, -1);
    check("t5_done_cyc", r_done, 66);
    check("t5_rb_words", r_rbw, snap);
    check("t5_chain", chain_a, P);

    // 10-bit chain, 4-bit words, partial last word.
    snap_b = chain_b;
    b_en = 0; b_done = -1; b_rb = 0; b_idx = 0; rbb = '0;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    for (int c = 1; c < 100; c++) begin
      if_b.cfg_valid = 1'b1;
      if_b.cfg_data  = (b_idx < 3) ? WB[11-4*b_idx -: 4] : 4'h0;
      if (en_b) b_en++;
      if (if_b.rb_valid) begin
        if (b_rb < 3) rbb[11-4*b_rb -: 4] = if_b.rb_data;
        b_rb++;
      end
      if (done_b && b_done < 0) b_done = c;
      if (if_b.cfg_valid && if_b.cfg_ready) b_idx++;
      @(posedge clk); #1;
      if (b_done >= 0) break;
    end
    if_b.cfg_valid = 1'b0;
    check("b_en_cnt", b_en, 10);
    check("b_done_cyc", b_done, 12);
    check("b_rb_cnt", b_rb, 3);
    check("b_rb_words", rbb, {snap_b, 2'b00});
    check("b_chain", chain_b, 10'b1111000010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
